// File: rtl/fare_pkg.sv
// Shared types and default constants for the taxi fare counter.
package fare_pkg;

    localparam int unsigned BCD_W = 16;

    localparam logic [BCD_W-1:0] DEF_BASE_FEE  = 16'h0100;
    localparam logic [BCD_W-1:0] DEF_BASE_DIST = 16'h0030;
    localparam logic [BCD_W-1:0] DEF_RATE      = 16'h0002;
    localparam logic [BCD_W-1:0] DEF_WAIT_RATE = 16'h0001;
    localparam logic [BCD_W-1:0] BCD_MAX       = 16'h9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fare_state_t;

endpackage

// File: rtl/bcd_add4.sv
// Combinational 4-digit BCD adder; a carry out of the top digit saturates to 9999.
module bcd_add4
    import fare_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    output logic [BCD_W-1:0] sum_c
);

    logic [4:0]       digit_sum;
    logic             carry;
    logic [BCD_W-1:0] raw_sum;

    // Ripple digit by digit with decimal carry, then clamp on overflow.
    always_comb begin
        digit_sum = '0;
        carry     = 1'b0;
        raw_sum   = '0;
        for (int i = 0; i < 4; i++) begin
            digit_sum = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
            if (digit_sum > 5'd9) begin
                raw_sum[4*i +: 4] = 4'(digit_sum - 5'd10);
                carry             = 1'b1;
            end else begin
                raw_sum[4*i +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        sum_c = carry ? BCD_MAX : raw_sum;
    end

endmodule

// File: rtl/fare_counter.sv
// Taxi fare counter: BCD distance and fare accumulated from wheel pulses.
// Optional waiting charge while stationary is enabled by defining FARE_WAIT_EN.
module fare_counter
    import fare_pkg::*;
#(
    parameter logic [BCD_W-1:0] BASE_FEE    = DEF_BASE_FEE,
    parameter logic [BCD_W-1:0] BASE_DIST   = DEF_BASE_DIST,
    parameter logic [BCD_W-1:0] RATE        = DEF_RATE,
    parameter int unsigned      WAIT_CYCLES = 50_000_000,
    parameter logic [BCD_W-1:0] WAIT_RATE   = DEF_WAIT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             wheel,
    output logic [BCD_W-1:0] fee,
    output logic [BCD_W-1:0] distance,
    output logic             running
);

    // Reject configurations that could never charge correctly.
    if (WAIT_CYCLES == 0 || WAIT_RATE > BCD_MAX) begin : g_cfg_check
        $error("fare_counter: invalid waiting-charge configuration");
    end

    fare_state_t      state_q, state_d;
    logic [BCD_W-1:0] fee_q, fee_d;
    logic [BCD_W-1:0] dist_q, dist_d;
    logic             running_q, running_d;
    logic             wheel_s1_q, wheel_s1_d;
    logic             wheel_s2_q, wheel_s2_d;
    logic             wheel_s3_q, wheel_s3_d;

    logic             wheel_rise_c;
    logic             wait_tick_c;
    logic [BCD_W-1:0] fee_inc_c;
    logic [BCD_W-1:0] dist_sum_c;
    logic [BCD_W-1:0] fee_sum_c;

    assign wheel_rise_c = wheel_s2_q & ~wheel_s3_q;

`ifdef FARE_WAIT_EN
    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign wait_tick_c = (state_q == RUN) && !wheel_rise_c
                         && (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1));

    // Idle-wheel cycle counter: runs only in RUN, restarts on motion or after a charge.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == RUN && !wheel_rise_c && !wait_tick_c) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign wait_tick_c = 1'b0;
`endif

    // Select what the fee adder adds this cycle; distance charge and wait charge never coincide.
    always_comb begin
        fee_inc_c = '0;
        if (wheel_rise_c && (dist_q >= BASE_DIST)) begin
            fee_inc_c = RATE;
        end else if (wait_tick_c) begin
            fee_inc_c = WAIT_RATE;
        end
    end

    bcd_add4 u_dist_add (
        .a     (dist_q),
        .b     (BCD_W'(1)),
        .sum_c (dist_sum_c)
    );

    bcd_add4 u_fee_add (
        .a     (fee_q),
        .b     (fee_inc_c),
        .sum_c (fee_sum_c)
    );

    // Next-state, synchronizer and output computation.
    always_comb begin
        state_d    = state_q;
        fee_d      = fee_q;
        dist_d     = dist_q;
        wheel_s1_d = wheel;
        wheel_s2_d = wheel_s1_q;
        wheel_s3_d = wheel_s2_q;

        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d = RUN;
                    dist_d  = '0;
                    fee_d   = BASE_FEE;
                end
            end
            RUN: begin
                if (wheel_rise_c) begin
                    dist_d = dist_sum_c;
                end
                fee_d = fee_sum_c;
                if (stop) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        running_d = (state_d == RUN);
    end

    // State, output and synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fee_q      <= '0;
            dist_q     <= '0;
            running_q  <= 1'b0;
            wheel_s1_q <= 1'b0;
            wheel_s2_q <= 1'b0;
            wheel_s3_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fee_q      <= fee_d;
            dist_q     <= dist_d;
            running_q  <= running_d;
            wheel_s1_q <= wheel_s1_d;
            wheel_s2_q <= wheel_s2_d;
            wheel_s3_q <= wheel_s3_d;
        end
    end

    assign fee      = fee_q;
    assign distance = dist_q;
    assign running  = running_q;

endmodule

// File: tb/tb_fare_counter.sv
// Directed self-checking bench for fare_counter and its BCD adder.
module tb_fare_counter;
    import fare_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        wheel = 1'b0;
    logic [15:0] fee;
    logic [15:0] distance;
    logic        running;

    logic [15:0] add_a = '0;
    logic [15:0] add_b = '0;
    logic [15:0] add_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    fare_counter #(
        .WAIT_CYCLES (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .wheel    (wheel),
        .fee      (fee),
        .distance (distance),
        .running  (running)
    );

    bcd_add4 u_add (
        .a     (add_a),
        .b     (add_b),
        .sum_c (add_s)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            wheel = 1'b1;
            tick();
            wheel = 1'b0;
            tick();
        end
        tick();
        tick();
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_fee,
                             input logic [15:0] exp_dist, input logic exp_run);
        check({tag, ".fee"}, fee, exp_fee);
        check({tag, ".dist"}, distance, exp_dist);
        check({tag, ".run"}, {15'd0, running}, {15'd0, exp_run});
    endtask

    task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        add_a = a;
        add_b = b;
        #1;
        check("bcd_add", add_s, s);
    endtask

    initial begin
        // Standalone adder vectors: decimal carries and saturation.
        add_vec(16'h0099, 16'h0001, 16'h0100);
        add_vec(16'h0999, 16'h0001, 16'h1000);
        add_vec(16'h1234, 16'h5678, 16'h6912);
        add_vec(16'h0005, 16'h0005, 16'h0010);
        add_vec(16'h9998, 16'h0002, 16'h9999);
        add_vec(16'h9999, 16'h0001, 16'h9999);

        // Reset state.
        #3 rst = 1'b1;
        tick();
        tick();
        check_out("reset", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        tick();

        // Wheel ignored in IDLE.
        pulses(3);
        check_out("idle_wheel", 16'h0000, 16'h0000, 1'b0);

        // Start loads the base fare on the next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("start", 16'h0100, 16'h0000, 1'b1);

        // Two-edge wheel latency.
        wheel = 1'b1;
        tick();
        check("lat_n", distance, 16'h0000);
        tick();
        check("lat_n1", distance, 16'h0000);
        tick();
        check("lat_n2", distance, 16'h0001);
        wheel = 1'b0;
        tick();

        // Base distance boundary.
        pulses(29);
        check_out("base30", 16'h0100, 16'h0030, 1'b1);
        pulses(1);
        check_out("first_charge", 16'h0102, 16'h0031, 1'b1);
        pulses(68);
        check_out("dist99", 16'h0238, 16'h0099, 1'b1);
        pulses(1);
        check_out("dist100", 16'h0240, 16'h0100, 1'b1);

        // Stop coinciding with a detected wheel edge: the pulse counts.
        wheel = 1'b1;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wheel = 1'b0;
        check_out("stop_edge", 16'h0242, 16'h0101, 1'b0);
        tick();
        pulses(3);
        check_out("hold_wheel", 16'h0242, 16'h0101, 1'b0);

        // start and stop together in HOLD: start wins.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_out("hold_both", 16'h0100, 16'h0000, 1'b1);
        pulses(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("run_start", 16'h0100, 16'h0001, 1'b1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_out("run_both", 16'h0100, 16'h0001, 1'b0);

        // Asynchronous reset mid-trip, between clock edges.
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses(3);
        check("pre_rst", distance, 16'h0003);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 16'h0000, 16'h0000, 1'b0);
        #1 rst = 1'b0;
        pulses(3);
        check_out("post_rst", 16'h0000, 16'h0000, 1'b0);

        // Saturation of fee and distance.
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses(4979);
        check_out("fee9998", 16'h9998, 16'h4979, 1'b1);
        pulses(1);
        check_out("fee_sat", 16'h9999, 16'h4980, 1'b1);
        pulses(5100);
        check_out("dist_sat", 16'h9999, 16'h9999, 1'b1);

        stop = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
`ifdef FARE_WAIT_EN
        check_out("wait_two", 16'h0102, 16'h0000, 1'b1);
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        wheel = 1'b1;
        tick();
        wheel = 1'b0;
        tick();
        tick();
        check("wait_wheel", distance, 16'h0001);
        for (int i = 0; i < 9; i++) tick();
        check("wait_before", fee, 16'h0100);
        tick();
        check("wait_after", fee, 16'h0101);
`else
        check_out("no_wait", 16'h0100, 16'h0000, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fare_counter.md
FARE_COUNTER -- requirements
Module: fare_counter

Interface
REQ-001 Parameter BASE_FEE, 16'h0100, 4-digit BCD starting fee in 0.1-yuan units (10.0).
REQ-002 Parameter BASE_DIST, 16'h0030, 4-digit BCD distance in 0.1 km covered by the starting fee (3.0 km).
REQ-003 Parameter RATE, 16'h0002, BCD fee added per 0.1 km beyond BASE_DIST.
REQ-004 Parameter WAIT_CYCLES, 50_000_000, idle-wheel clock count per waiting charge.
REQ-005 Parameter WAIT_RATE, 16'h0001, BCD fee added per waiting charge.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  synchronous single-cycle strobe that begins a trip.
REQ-009 stop  in  1  synchronous single-cycle strobe that ends a trip.
REQ-010 wheel  in  1  asynchronous level; each rising edge = 0.1 km travelled.
REQ-011 fee  out  16  4-digit BCD fare, XXX.X yuan, registered.
REQ-012 distance  out  16  4-digit BCD distance, XXX.X km, registered.
REQ-013 running  out  1  high only in state RUN, registered.

Function
REQ-014 States IDLE, RUN, HOLD; IDLE after reset.
REQ-015 IDLE/HOLD + start: -> RUN, distance <= 16'h0000, fee <= BASE_FEE, same edge.
REQ-016 RUN + stop: -> HOLD, fee and distance frozen; start in RUN is ignored.
REQ-017 start and stop in the same cycle: stop wins in RUN, start wins in IDLE/HOLD.
REQ-018 wheel passes a 2-flop synchronizer then rising-edge detect; a low-to-high wheel sampled at edge N updates outputs at edge N+2.
REQ-019 Detected wheel edge in RUN: distance += 1 (BCD); if pre-increment distance >= BASE_DIST, fee += RATE (BCD) on the same edge.
REQ-020 Wheel edge coinciding with stop in RUN is counted; wheel edges in IDLE/HOLD are ignored.
REQ-021 All additions are BCD with decimal carry across 4 digits; a result above 9999 saturates to 16'h9999 per field.
REQ-022 Saturated distance still holds at 16'h9999 on further pulses; fee keeps charging RATE until saturated.
REQ-023 Outputs only ever hold valid BCD digits (0-9).

Reset
REQ-024 rst high: state IDLE, fee 16'h0000, distance 16'h0000, running 0, synchronizer and wait counter cleared, immediately and regardless of clk.
REQ-025 rst asserted mid-trip abandons the trip; release returns to IDLE and requires a new start.

Configuration
REQ-026 FARE_WAIT_EN defined: in RUN a counter counts cycles without a detected wheel edge; on reaching WAIT_CYCLES, fee += WAIT_RATE (saturating) and the counter restarts at 0.
REQ-027 Wait counter clears on every detected wheel edge, on entry to RUN, and outside RUN.
REQ-028 FARE_WAIT_EN undefined: no wait counter logic exists; fee changes only per REQ-015/019; WAIT_CYCLES and WAIT_RATE are unused.

Structure
REQ-029 Shared package fare_pkg holds the state enum, BCD_W=16, and the default fee/distance/rate constants.
REQ-030 One combinational sub-module bcd_add4: two 4-digit BCD operands in, saturating 4-digit BCD sum out, instantiated for distance and fee paths.

Verification
REQ-031 Reset then start -> next edge fee=16'h0100, distance=16'h0000, running=1.
REQ-032 30 wheel pulses after start -> distance=16'h0030, fee=16'h0100; 31st pulse -> distance=16'h0031, fee=16'h0102.
REQ-033 Distance forced to 16'h0099 then pulse -> 16'h0100; fee 16'h9998 plus RATE -> 16'h9999 saturated.
REQ-034 stop with coincident wheel edge -> that pulse counted, running=0, later pulses ignored, values held; start -> cleared to base.
REQ-035 rst pulsed between clk edges mid-trip -> outputs 0 and state IDLE without a clock edge; wheel pulses then ignored.
REQ-036 FARE_WAIT_EN with WAIT_CYCLES=10, no wheel in RUN for 20 cycles -> fee=16'h0102; a wheel edge at cycle 5 restarts counting.
